matmul_seq_ctrl: RTL

Sequential controller for N x N unsigned matrix multiplication with one shared multiply-accumulate unit, for area-constrained use where the fully parallel multiplier is too large.
- Accepts m1 then m2 as a valid/ready element stream, row-major, and stores them in internal buffers.
- Computes each output element in ROW_COL_SIZE MAC cycles.
- Streams the result matrix row-major on a valid/ready output with a last flag.
- Result values are identical to the parallel multiplier's output for the same inputs.

---
 rtl/matmul_pkg.sv | 24 ++
 rtl/mac_unit.sv | 36 +++
 rtl/matmul_seq_ctrl.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/matmul_pkg.sv
`default_nettype none
// ============================================================================
// Module      : matmul_pkg
// Description : Shared types and helpers for the matrix multiplier family:
//               controller state encoding and output width calculation.
// Revision    : 1.0 - initial release
// ============================================================================
package matmul_pkg;

    // Controller states: load m1, load m2, accumulate one element, present it
    typedef enum logic [1:0] {
        LOAD_A = 2'd0,
        LOAD_B = 2'd1,
        MAC    = 2'd2,
        OUT    = 2'd3
    } state_t;

    // Width needed to hold a sum of n products of two bit_size-wide operands
    function automatic int out_m_bit_size(input int bit_size, input int n);
        return 2 * bit_size + $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mac_unit.sv
`default_nettype none
// ============================================================================
// Module      : mac_unit
// Description : Registered unsigned multiply-accumulate. clr wins over en.
// Revision    : 1.0 - initial release
// ============================================================================
module mac_unit
    import matmul_pkg::*;
#(
    parameter int BIT_SIZE       = 8,
    parameter int OUT_M_BIT_SIZE = out_m_bit_size(8, 3)
) (
    input  logic                      clk,
    input  logic                      n_rst,
    input  logic                      clr,
    input  logic                      en,
    input  logic [BIT_SIZE-1:0]       x,
    input  logic [BIT_SIZE-1:0]       y,
    output logic [OUT_M_BIT_SIZE-1:0] acc
);

    logic [2*BIT_SIZE-1:0] prod;

    assign prod = x * y;

    // Accumulator: cleared by reset or clr, otherwise adds the product when enabled
    always_ff @(posedge clk) begin
        if (!n_rst || clr) begin
            acc <= '0;
        end else if (en) begin
            acc <= acc + OUT_M_BIT_SIZE'(prod);
        end
    end

endmodule
`default_nettype wire

// File: rtl/matmul_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : matmul_seq_ctrl
// Description : Sequential N x N unsigned matrix multiplier. Loads m1 and m2
//               as a row-major stream, computes each result element with one
//               shared MAC over N cycles, streams the result row-major.
// Revision    : 1.0 - initial release
// ============================================================================
module matmul_seq_ctrl
    import matmul_pkg::*;
#(
    parameter int BIT_SIZE       = 8,
    parameter int ROW_COL_SIZE   = 3,
    parameter int OUT_M_BIT_SIZE = out_m_bit_size(BIT_SIZE, ROW_COL_SIZE),
    parameter int IDX_W          = $clog2(ROW_COL_SIZE * ROW_COL_SIZE * 2)
) (
    input  logic                      clk,
    input  logic                      n_rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [BIT_SIZE-1:0]       in_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [OUT_M_BIT_SIZE-1:0] out_data,
    output logic                      out_last,
    output logic                      busy
);

    localparam int NN   = ROW_COL_SIZE * ROW_COL_SIZE;
    localparam int AW   = $clog2(NN);
    localparam int RC_W = $clog2(ROW_COL_SIZE);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NN - 1);
    localparam logic [RC_W-1:0]  LAST_RC  = RC_W'(ROW_COL_SIZE - 1);

    state_t state, state_d;
    logic [IDX_W-1:0] idx, idx_d;
    logic [RC_W-1:0]  r, r_d, c, c_d, k, k_d;
    logic             wr_a, wr_b, mac_clr, mac_en;

    logic [BIT_SIZE-1:0] a_buf [NN];
    logic [BIT_SIZE-1:0] b_buf [NN];
    logic [AW-1:0]       a_addr, b_addr;
    logic [OUT_M_BIT_SIZE-1:0] acc;

    // a[r][k] and b[k][c] in row-major flat buffers
    assign a_addr = AW'(r) * AW'(ROW_COL_SIZE) + AW'(k);
    assign b_addr = AW'(k) * AW'(ROW_COL_SIZE) + AW'(c);

    // The accumulator holds the finished sum for the whole OUT state
    assign out_data = (state == OUT) ? acc : '0;
    assign busy     = !((state == LOAD_A) && (idx == '0));

    mac_unit #(
        .BIT_SIZE       (BIT_SIZE),
        .OUT_M_BIT_SIZE (OUT_M_BIT_SIZE)
    ) u_mac (
        .clk   (clk),
        .n_rst (n_rst),
        .clr   (mac_clr),
        .en    (mac_en),
        .x     (a_buf[a_addr]),
        .y     (b_buf[b_addr]),
        .acc   (acc)
    );

    // Operand buffers; contents are don't-care after reset
    always_ff @(posedge clk) begin
        if (wr_a) a_buf[idx[AW-1:0]] <= in_data;
        if (wr_b) b_buf[idx[AW-1:0]] <= in_data;
    end

    // State and counter registers
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state <= LOAD_A;
            idx   <= '0;
            r     <= '0;
            c     <= '0;
            k     <= '0;
        end else begin
            state <= state_d;
            idx   <= idx_d;
            r     <= r_d;
            c     <= c_d;
            k     <= k_d;
        end
    end

    // Next-state, counter updates and handshake outputs
    always_comb begin
        state_d   = state;
        idx_d     = idx;
        r_d       = r;
        c_d       = c;
        k_d       = k;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_last  = 1'b0;
        wr_a      = 1'b0;
        wr_b      = 1'b0;
        mac_clr   = 1'b0;
        mac_en    = 1'b0;
        unique case (state)
            LOAD_A: begin
                in_ready = 1'b1;
                mac_clr  = 1'b1;
                if (in_valid) begin
                    wr_a = 1'b1;
                    if (idx == LAST_IDX) begin
                        idx_d   = '0;
                        state_d = LOAD_B;
                    end else begin
                        idx_d = idx + IDX_W'(1);
                    end
                end
            end
            LOAD_B: begin
                in_ready = 1'b1;
                mac_clr  = 1'b1;
                if (in_valid) begin
                    wr_b = 1'b1;
                    if (idx == LAST_IDX) begin
                        idx_d   = '0;
                        r_d     = '0;
                        c_d     = '0;
                        k_d     = '0;
                        state_d = MAC;
                    end else begin
                        idx_d = idx + IDX_W'(1);
                    end
                end
            end
            MAC: begin
                mac_en = 1'b1;
                if (k == LAST_RC) begin
                    k_d     = '0;
                    state_d = OUT;
                end else begin
                    k_d = k + RC_W'(1);
                end
            end
            OUT: begin
                out_valid = 1'b1;
                out_last  = (r == LAST_RC) && (c == LAST_RC);
                if (out_ready) begin
                    mac_clr = 1'b1;
                    k_d     = '0;
                    if (out_last) begin
                        idx_d   = '0;
                        r_d     = '0;
                        c_d     = '0;
                        state_d = LOAD_A;
                    end else begin
                        state_d = MAC;
                        if (c == LAST_RC) begin
                            c_d = '0;
                            r_d = r + RC_W'(1);
                        end else begin
                            c_d = c + RC_W'(1);
                        end
                    end
                end
            end
            default: state_d = LOAD_A;
        endcase
    end

endmodule
`default_nettype wire
